// File: rtl/wt_mem_responder.sv
// Memory-side responder for the write-through cache memory channel: serves loads/stores
// from a local word array and returns tagged responses in acceptance order after a fixed latency.
module wt_mem_responder #(
  parameter int AddrWidth = 12,
  parameter int TidWidth  = 2,
  parameter int FifoDepth = 4,
  parameter int Latency   = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                mem_data_req_i,
  output logic                mem_data_ack_o,
  input  logic                mem_rtype_i,
  input  logic [TidWidth-1:0] mem_tid_i,
  input  logic [AddrWidth-1:0] mem_paddr_i,
  input  logic [1:0]          mem_size_i,
  input  logic [63:0]         mem_wdata_i,
  output logic                mem_rtrn_vld_o,
  output logic                mem_rtrn_type_o,
  output logic [TidWidth-1:0] mem_rtrn_tid_o,
  output logic [63:0]         mem_rtrn_data_o,
  output logic                busy_o
);
  localparam int Words = 2 ** (AddrWidth - 3);
  localparam int PtrW  = $clog2(FifoDepth);
  localparam int CntW  = $clog2(Latency + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(Latency - 1);
  localparam bit Bypass = (Latency == 1);

  // Handshake: the requester holds req and its fields stable until it sees ack high in a
  // cycle; that cycle is the transfer. Returns are fire-and-forget pulses with no ready.

  logic [63:0]         mem_q  [Words];
  logic                rtype_q[FifoDepth];
  logic [TidWidth-1:0] tid_q  [FifoDepth];
  logic [63:0]         data_q [FifoDepth];
  logic [CntW-1:0]     cnt_q  [FifoDepth];
  logic [PtrW:0]       wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic                rtrn_vld_q, rtrn_type_q, busy_q;
  logic [TidWidth-1:0] rtrn_tid_q;
  logic [63:0]         rtrn_data_q;

  logic [PtrW-1:0]      wr_idx, rd_idx;
  logic                 empty, full, pop, ack, bypass, push;
  logic [AddrWidth-4:0] word_idx;
  logic [2:0]           byte_off;
  logic [7:0]           size_mask, byte_en;
  logic [63:0]          cur_word, wr_word;

  assign wr_idx = wr_ptr_q[PtrW-1:0];
  assign rd_idx = rd_ptr_q[PtrW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) && (wr_idx == rd_idx);
  // The head's count reaches zero on the same edge that loads the return register.
  assign pop    = !empty && (cnt_q[rd_idx] <= CntW'(1));
  assign ack    = mem_data_req_i && rst_ni && (!full || pop);
  assign bypass = Bypass && empty && ack;
  assign push   = ack && !bypass;

  assign wr_ptr_d = wr_ptr_q + {{PtrW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{PtrW{1'b0}}, pop};

  assign word_idx = mem_paddr_i[AddrWidth-1:3];
  assign byte_off = mem_paddr_i[2:0] & (3'b111 << mem_size_i);
  assign byte_en  = size_mask << byte_off;
  assign cur_word = mem_q[word_idx];

  always_comb begin
    size_mask = 8'h01;
    case (mem_size_i)
      2'd0: size_mask = 8'h01;
      2'd1: size_mask = 8'h03;
      2'd2: size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  always_comb begin
    wr_word = cur_word;
    for (int b = 0; b < 8; b++) begin
      if (byte_en[b]) wr_word[8*b +: 8] = mem_wdata_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 0; w < Words; w++) mem_q[w] <= '0;
    end else if (ack && mem_rtype_i) begin
      mem_q[word_idx] <= wr_word;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rtrn_vld_q  <= 1'b0;
      rtrn_type_q <= 1'b0;
      rtrn_tid_q  <= '0;
      rtrn_data_q <= '0;
      busy_q      <= 1'b0;
      for (int i = 0; i < FifoDepth; i++) begin
        rtype_q[i] <= 1'b0;
        tid_q[i]   <= '0;
        data_q[i]  <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < FifoDepth; i++) begin
        if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - CntW'(1);
      end
      if (push) begin
        rtype_q[wr_idx] <= mem_rtype_i;
        tid_q[wr_idx]   <= mem_tid_i;
        data_q[wr_idx]  <= mem_rtype_i ? 64'd0 : cur_word;
        cnt_q[wr_idx]   <= CntInit;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      busy_q   <= (wr_ptr_d != rd_ptr_d);
      if (pop) begin
        rtrn_vld_q  <= 1'b1;
        rtrn_type_q <= rtype_q[rd_idx];
        rtrn_tid_q  <= tid_q[rd_idx];
        rtrn_data_q <= data_q[rd_idx];
      end else if (bypass) begin
        rtrn_vld_q  <= 1'b1;
        rtrn_type_q <= mem_rtype_i;
        rtrn_tid_q  <= mem_tid_i;
        rtrn_data_q <= mem_rtype_i ? 64'd0 : cur_word;
      end else begin
        rtrn_vld_q  <= 1'b0;
        rtrn_type_q <= 1'b0;
        rtrn_tid_q  <= '0;
        rtrn_data_q <= '0;
      end
    end
  end

  assign mem_data_ack_o  = ack;
  assign mem_rtrn_vld_o  = rtrn_vld_q;
  assign mem_rtrn_type_o = rtrn_type_q;
  assign mem_rtrn_tid_o  = rtrn_tid_q;
  assign mem_rtrn_data_o = rtrn_data_q;
  assign busy_o          = busy_q;
endmodule

// File: tb/tb_wt_mem_responder.sv
// Bench for wt_mem_responder: two instances (Latency 2 and 6) checked every cycle against a
// transaction-level model of acceptance, byte memory contents and in-order return timing.
module tb_wt_mem_responder;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  logic [1:0]       req, rtype_i, ack, vld, rt_o, busy;
  logic [1:0][1:0]  tid_i, size_i, tid_o;
  logic [1:0][11:0] paddr;
  logic [1:0][63:0] wdata, data_o;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wt_mem_responder u_a (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_data_req_i(req[0]), .mem_data_ack_o(ack[0]), .mem_rtype_i(rtype_i[0]),
    .mem_tid_i(tid_i[0]), .mem_paddr_i(paddr[0]), .mem_size_i(size_i[0]),
    .mem_wdata_i(wdata[0]), .mem_rtrn_vld_o(vld[0]), .mem_rtrn_type_o(rt_o[0]),
    .mem_rtrn_tid_o(tid_o[0]), .mem_rtrn_data_o(data_o[0]), .busy_o(busy[0])
  );

  wt_mem_responder #(.Latency(6)) u_b (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_data_req_i(req[1]), .mem_data_ack_o(ack[1]), .mem_rtype_i(rtype_i[1]),
    .mem_tid_i(tid_i[1]), .mem_paddr_i(paddr[1]), .mem_size_i(size_i[1]),
    .mem_wdata_i(wdata[1]), .mem_rtrn_vld_o(vld[1]), .mem_rtrn_type_o(rt_o[1]),
    .mem_rtrn_tid_o(tid_o[1]), .mem_rtrn_data_o(data_o[1]), .busy_o(busy[1])
  );

  // Reference model state
  typedef struct {
    int          idx;
    int          r;
    logic        rtype;
    logic [1:0]  tid;
    logic [63:0] data;
  } ret_t;

  ret_t        exp_q[$];
  logic [7:0]  ref_mem [2][4096];
  int          lat [2] = '{2, 6};
  int          last_r [2] = '{0, 0};
  bit   [1:0]  acc_flag, use_exp;
  logic [1:0][63:0] exp_dat;
  int          nchecks = 0;
  int          nerr = 0;

  task automatic chk(int i, string name, logic [127:0] act, logic [127:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s inst%0d cyc%0d: got %h expected %h", name, i, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      last_r[i] = 0;
      for (int a = 0; a < 4096; a++) ref_mem[i][a] = 8'h00;
    end
  endtask

  task automatic mon(int i);
    int c, occ, first;
    bit popn, exp_ack;
    logic [63:0] word;
    ret_t e;
    c = cyc;
    if (!rst_n) begin
      chk(i, "reset_outs", {ack[i], vld[i], rt_o[i], tid_o[i], data_o[i], busy[i]}, '0);
      model_clear();
      return;
    end
    occ = 0; popn = 0; first = -1;
    foreach (exp_q[k]) begin
      if (exp_q[k].idx == i) begin
        if (exp_q[k].r > c) occ++;
        if (exp_q[k].r == c + 1) popn = 1;
        if (first < 0) first = k;
      end
    end
    exp_ack = req[i] && (occ < 4 || popn);
    chk(i, "ack", ack[i], exp_ack);
    if (first >= 0 && exp_q[first].r == c) begin
      chk(i, "rtrn", {vld[i], rt_o[i], tid_o[i], data_o[i]},
          {1'b1, exp_q[first].rtype, exp_q[first].tid, exp_q[first].data});
      exp_q.delete(first);
    end else begin
      chk(i, "rtrn_idle", {vld[i], rt_o[i], tid_o[i], data_o[i]}, '0);
    end
    chk(i, "busy", busy[i], occ > 0);
    if (exp_ack) begin
      int base, off, n;
      base = int'(paddr[i]) & ~7;
      n    = 1 << size_i[i];
      off  = (int'(paddr[i]) & 7) & ~(n - 1);
      if (rtype_i[i]) begin
        for (int b = 0; b < n; b++)
          ref_mem[i][base + off + b] = wdata[i][(off + b) * 8 +: 8];
        word = 64'd0;
      end else begin
        for (int b = 0; b < 8; b++) word[b * 8 +: 8] = ref_mem[i][base + b];
      end
      if (use_exp[i]) word = exp_dat[i];
      e.idx = i;
      e.r = (c + lat[i] > last_r[i] + 1) ? c + lat[i] : last_r[i] + 1;
      last_r[i] = e.r;
      e.rtype = rtype_i[i];
      e.tid = tid_i[i];
      e.data = word;
      exp_q.push_back(e);
      acc_flag[i] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) mon(i);
  end

  // Called #1 after a rising edge; returns #1 after the edge that accepted the request.
  task automatic send(int i, bit rt, int t, int a, int sz, logic [63:0] wd, bit ue, logic [63:0] ed);
    use_exp[i] = ue;
    exp_dat[i] = ed;
    rtype_i[i] = rt;
    tid_i[i]   = 2'(t);
    paddr[i]   = 12'(a);
    size_i[i]  = 2'(sz);
    wdata[i]   = wd;
    req[i]     = 1'b1;
    acc_flag[i] = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      if (acc_flag[i]) break;
    end
    if (!acc_flag[i]) begin
      nchecks++;
      nerr++;
      $display("FAIL accept_timeout inst%0d cyc%0d: got no accept expected accept", i, cyc);
    end
    #1;
    req[i] = 1'b0;
    use_exp[i] = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          rt;
    int          tid;
    int          addr;
    int          size;
    logic [63:0] wd;
    logic [63:0] ed;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{0, 1, 'h010, 3, 64'h0, 64'h0};
    tbl[1] = '{1, 2, 'h020, 3, 64'h11223344_55667788, 64'h0};
    tbl[2] = '{0, 3, 'h020, 3, 64'h0, 64'h11223344_55667788};
    tbl[3] = '{1, 0, 'h023, 0, 64'h00000000_AB000000, 64'h0};
    tbl[4] = '{0, 1, 'h020, 3, 64'h0, 64'h11223344_AB667788};
    tbl[5] = '{1, 2, 'h026, 2, 64'hDEADBEEF_00000000, 64'h0};
    tbl[6] = '{0, 3, 'h020, 3, 64'h0, 64'hDEADBEEF_AB667788};
    tbl[7] = '{0, 0, 'h027, 1, 64'h0, 64'hDEADBEEF_AB667788};

    rst_n = 1'b0;
    req = '0; rtype_i = '0; tid_i = '0; paddr = '0; size_i = '0; wdata = '0;
    acc_flag = '0; use_exp = '0; exp_dat = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Directed table on the Latency=2 instance, issued back-to-back
    for (int k = 0; k < 8; k++)
      send(0, tbl[k].rt, tbl[k].tid, tbl[k].addr, tbl[k].size, tbl[k].wd, 1'b1, tbl[k].ed);
    idle(5);

    // Six requests held back-to-back on the Latency=6 instance: queue fills and stalls
    for (int k = 0; k < 6; k++) send(1, 1'b0, k % 4, 8 * k, 3, 64'h0, 1'b0, 64'h0);
    idle(14);

    // Randomized traffic on both instances
    for (int k = 0; k < 80; k++) begin
      int i, a;
      i = $urandom_range(0, 1);
      a = $urandom_range(0, 63) | ($urandom_range(0, 1) != 0 ? 'hFC0 : 0);
      send(i, 1'($urandom_range(0, 1)), $urandom_range(0, 3), a, $urandom_range(0, 3),
           {$urandom, $urandom}, 1'b0, 64'h0);
      idle($urandom_range(0, 2));
    end
    idle(14);

    // Reset with three loads outstanding drops them and clears memory
    send(1, 1'b1, 1, 'h100, 3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0);
    idle(8);
    send(1, 1'b0, 1, 'h100, 3, 64'h0, 1'b0, 64'h0);
    send(1, 1'b0, 2, 'h100, 3, 64'h0, 1'b0, 64'h0);
    send(1, 1'b0, 3, 'h100, 3, 64'h0, 1'b0, 64'h0);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(10);
    send(1, 1'b0, 0, 'h100, 3, 64'h0, 1'b1, 64'h0);
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule

// File: doc/wt_mem_responder.md
Name: wt_mem_responder

Overview:
- Memory-side responder for the write-through cache memory interface: the far end of the cache-to-memory request/return channel that a cache drives.
- Accepts load and store requests via a req/ack handshake and serves them from an internal byte-addressable memory array.
- Returns in-order responses tagged with the transaction ID after a fixed minimum latency.
- Used as a synthesizable backing store for cache-subsystem unit benches and for FPGA bring-up without an AXI/L1.5 fabric.

Parameters:
- AddrWidth, 12, byte-address width; memory holds 2^(AddrWidth-3) 64-bit words.
- TidWidth, 2, transaction ID width.
- FifoDepth, 4, outstanding-request queue depth; power of 2, >=2.
- Latency, 2, minimum cycles from acceptance to return; must be >=1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- mem_data_req_i  in  1  request valid; held by the requester until acked
- mem_data_ack_o  out  1  single-cycle acceptance pulse
- mem_rtype_i  in  1  0=load, 1=store
- mem_tid_i  in  TidWidth  transaction ID
- mem_paddr_i  in  AddrWidth  byte address
- mem_size_i  in  2  log2 bytes: 0=1B, 1=2B, 2=4B, 3=8B
- mem_wdata_i  in  64  store data, byte-lane aligned to paddr[2:0]
- mem_rtrn_vld_o  out  1  return valid, one-cycle pulse per response
- mem_rtrn_type_o  out  1  echoes rtype
- mem_rtrn_tid_o  out  TidWidth  echoes tid
- mem_rtrn_data_o  out  64  full 64-bit word for loads; 0 for stores
- busy_o  out  1  queue non-empty

Behaviour:
- Reset (async, rst_ni low):
  - Queue emptied; all entry countdowns cleared.
  - All outputs 0.
  - Memory array cleared to 0.
  - Reset during an outstanding transaction drops it; no return is ever issued for it.
- Acceptance:
  - mem_data_ack_o = mem_data_req_i && (!full || pop_this_cycle). This is combinational, so the ack can fall in the same cycle as the req.
  - At most one accept per cycle.
  - Request fields are sampled in the ack cycle.
- Address alignment: byte offset = paddr[2:0] with its low mem_size_i bits forced to 0. Word index = paddr[AddrWidth-1:3].
- Store:
  - Memory is written in the accept cycle, only on the bytes covered by size and offset.
  - Write data is taken from the matching lanes of mem_wdata_i.
  - Other bytes are unchanged.
- Load:
  - The full word is read in the accept cycle, after any same-cycle store has been applied. Only one request is accepted per cycle, so no conflict arises.
  - The read word is stored in the queue entry.
- Each queue entry holds rtype, tid, data and a countdown.
  - Countdown is loaded with Latency-1 at accept.
  - Countdown decrements each cycle and saturates at 0.
- Return:
  - The head entry pops when its countdown is 0: mem_rtrn_vld_o=1 with the head's fields, registered.
  - The earliest return for a request accepted in cycle t is cycle t+Latency.
  - Returns are strictly in acceptance order; at most one per cycle.
  - Back-to-back accepts therefore give back-to-back returns.
  - There is no return back-pressure.
- Outputs when mem_rtrn_vld_o=0: type/tid/data are held at 0.
- Full: with FifoDepth entries and no pop, ack stays 0 and the request is held by the requester.
  - If a pop occurs in the same cycle, a new request is accepted into the freed slot.
- Pointer wrap-around: read/write pointers have log2(FifoDepth)+1 bits. full = MSBs differ and the rest are equal.
- busy_o = queue non-empty, registered.

Test Plan:
- Reset then load tid=1 from paddr 0x010 size 3 -> ack in the same cycle as req; rtrn_vld exactly 2 cycles later, tid=1, type=0, data=0x0.
- Store 0x11223344_55667788 to 0x020 size 3, then load 0x020 -> store return data 0; load return 0x1122334455667788; returns in order on consecutive cycles if requests were back-to-back.
- Store byte 0xAB at 0x023 (size 0), then load 0x020 -> only byte lane 3 changes: 0x11223344_AB667788.
- Misaligned size-2 store to 0x026 with data in lanes 4..7 -> bytes 4..7 of word 0x020 are written; offset forced to 4.
- Hold req high for 6 requests with Latency=4, FifoDepth=4 -> 4 accepted immediately, 5th ack coincides with the first rtrn_vld; returns carry tids in issue order; busy_o falls after the final return.
- Assert rst_ni low with 3 requests outstanding -> no further rtrn_vld; busy_o=0; a subsequent load returns 0.
